// File: rtl/receiver_if.sv
// Serial receive bus: line, baud tick and acknowledge toward the receiver; byte, ready flag
// (and the framing-error pulse when RX_FRAMING_CHECK_EN is defined) back to the consumer.
interface receiver_if;
  logic       rx;
  logic       clken;
  logic       rdy_clr;
  logic [7:0] data;
  logic       rdy;
`ifdef RX_FRAMING_CHECK_EN
  logic       ferr;

  modport master (output rx, clken, rdy_clr, input data, rdy, ferr);
  modport slave  (input rx, clken, rdy_clr, output data, rdy, ferr);
`else
  modport master (output rx, clken, rdy_clr, input data, rdy);
  modport slave  (input rx, clken, rdy_clr, output data, rdy);
`endif
endinterface

// File: rtl/receiver.sv
// UART 8N1 receiver, 16x oversampled on the shared baud clock-enable.
// Define RX_FRAMING_CHECK_EN to drop bytes with a low stop bit and pulse ferr instead.
module receiver (
  input  logic       clk_50m,
  input  logic       rst,
  receiver_if.slave  rx_bus
);
  localparam int unsigned DataW   = 8;
  localparam int unsigned SampleW = 4;
  localparam int unsigned PosW    = 3;

  typedef enum logic [1:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_STOP
  } state_e;

  state_e             state_q, state_d;
  logic [SampleW-1:0] sample_q, sample_d;
  logic [PosW-1:0]    bit_pos_q, bit_pos_d;
  logic [DataW-1:0]   scratch_q, scratch_d;
  logic [DataW-1:0]   data_q, data_d;
  logic               rdy_q, rdy_d;
  logic               rx_meta_q, rx_s_q;
`ifdef RX_FRAMING_CHECK_EN
  logic               ferr_q, ferr_d;
`endif

  // State and output registers; the rx synchronizer idles high like the line
  always_ff @(posedge clk_50m) begin
    if (rst) begin
      state_q   <= RX_IDLE;
      sample_q  <= '0;
      bit_pos_q <= '0;
      scratch_q <= '0;
      data_q    <= '0;
      rdy_q     <= 1'b0;
      rx_meta_q <= 1'b1;
      rx_s_q    <= 1'b1;
`ifdef RX_FRAMING_CHECK_EN
      ferr_q    <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      sample_q  <= sample_d;
      bit_pos_q <= bit_pos_d;
      scratch_q <= scratch_d;
      data_q    <= data_d;
      rdy_q     <= rdy_d;
      rx_meta_q <= rx_bus.rx;
      rx_s_q    <= rx_meta_q;
`ifdef RX_FRAMING_CHECK_EN
      ferr_q    <= ferr_d;
`endif
    end
  end

  // Next state; a stop-bit set of rdy overrides a same-cycle clear
  always_comb begin
    state_d   = state_q;
    sample_d  = sample_q;
    bit_pos_d = bit_pos_q;
    scratch_d = scratch_q;
    data_d    = data_q;
    rdy_d     = rdy_q & ~rx_bus.rdy_clr;
`ifdef RX_FRAMING_CHECK_EN
    ferr_d    = 1'b0;
`endif
    if (rx_bus.clken) begin
      unique case (state_q)
        RX_IDLE: begin
          if (!rx_s_q) begin
            sample_d = SampleW'(1);
            state_d  = RX_START;
          end
        end
        RX_START: begin
          if (rx_s_q) begin
            sample_d = '0;
            state_d  = RX_IDLE;
          end else if (sample_q == SampleW'(7)) begin
            sample_d  = '0;
            bit_pos_d = '0;
            state_d   = RX_DATA;
          end else begin
            sample_d = sample_q + SampleW'(1);
          end
        end
        RX_DATA: begin
          sample_d = sample_q + SampleW'(1);
          if (sample_q == '1) begin
            scratch_d[bit_pos_q] = rx_s_q;
            if (bit_pos_q == '1) begin
              state_d = RX_STOP;
            end else begin
              bit_pos_d = bit_pos_q + PosW'(1);
            end
          end
        end
        RX_STOP: begin
          sample_d = sample_q + SampleW'(1);
          if (sample_q == '1) begin
            state_d = RX_IDLE;
`ifdef RX_FRAMING_CHECK_EN
            if (rx_s_q) begin
              data_d = scratch_q;
              rdy_d  = 1'b1;
            end else begin
              ferr_d = 1'b1;
            end
`else
            data_d = scratch_q;
            rdy_d  = 1'b1;
`endif
          end
        end
        default: state_d = RX_IDLE;
      endcase
    end
  end

  assign rx_bus.data = data_q;
  assign rx_bus.rdy  = rdy_q;
`ifdef RX_FRAMING_CHECK_EN
  assign rx_bus.ferr = ferr_q;
`endif
endmodule

// File: tb/tb_receiver.sv
// Bench for receiver: directed 8N1 frames against a clken-indexed frame model, plus literal checks.
module tb_receiver;
  localparam int ClkenDiv = 27;
  localparam int BitCyc   = 16 * ClkenDiv;

  logic clk_50m = 1'b0;
  logic rst;
  receiver_if bus();

  receiver dut (
    .clk_50m (clk_50m),
    .rst     (rst),
    .rx_bus  (bus)
  );

  always #10 clk_50m = ~clk_50m;

  int checks = 0;
  int errors = 0;
  bit cmp_en = 1'b0;

  // Tick generator; also issues requested rdy_clr pulses
  int unsigned div_cnt  = 0;
  int          clr_reqs = 0;
  int          clr_acks = 0;
  int          arm_id   = 0;
  int          coinc_id = 0;
  logic        m_stop_next;

  always @(negedge clk_50m) begin
    div_cnt = (div_cnt == ClkenDiv - 1) ? 0 : div_cnt + 1;
    bus.clken   = (div_cnt == ClkenDiv - 1);
    bus.rdy_clr = 1'b0;
    if (clr_reqs != clr_acks) begin
      bus.rdy_clr = 1'b1;
      clr_acks    = clr_reqs;
    end
    if (bus.clken && arm_id != coinc_id && m_stop_next) begin
      bus.rdy_clr = 1'b1;
      coinc_id    = arm_id;
    end
  end

  // Model: tracks clken indices; a frame is detection index D, sampled at D+7+16*(n+1), stop at D+151
  logic              m_s1, m_s2;
  int                m_mode = 0;
  int unsigned       m_idx  = 0;
  int unsigned       m_det  = 0;
  logic [7:0]        m_byte = 8'h00;
  logic [7:0]        m_data;
  logic              m_rdy, m_ferr;

  always @(posedge clk_50m) begin
    logic rxs;
    int   k;
    if (rst) begin
      m_s1 = 1'b1; m_s2 = 1'b1; m_mode = 0;
      m_rdy = 1'b0; m_data = 8'h00; m_ferr = 1'b0; m_stop_next = 1'b0;
    end else begin
      rxs  = m_s2;
      m_s2 = m_s1;
      m_s1 = bus.rx;
      m_rdy  = m_rdy & ~bus.rdy_clr;
      m_ferr = 1'b0;
      if (bus.clken) begin
        case (m_mode)
          0: if (!rxs) begin m_mode = 1; m_det = m_idx; end
          1: begin
            if (rxs) m_mode = 0;
            else if (m_idx == m_det + 7) m_mode = 2;
          end
          default: begin
            k = int'(m_idx - (m_det + 7));
            if (k % 16 == 0 && k <= 128) m_byte[k/16-1] = rxs;
            if (k == 144) begin
`ifdef RX_FRAMING_CHECK_EN
              if (rxs) begin m_rdy = 1'b1; m_data = m_byte; end
              else m_ferr = 1'b1;
`else
              m_rdy = 1'b1; m_data = m_byte;
`endif
              m_mode = 0;
            end
          end
        endcase
        m_idx++;
      end
      m_stop_next = (m_mode == 2) && (m_idx == m_det + 151);
    end
  end

  // Cycle compare of DUT outputs against the model
  int dut_ferr_cycles = 0;
  always @(negedge clk_50m) begin
    if (cmp_en) begin
      checks++;
      if (bus.rdy !== m_rdy || bus.data !== m_data) begin
        errors++;
        $display("FAIL cycle_cmp t=%0t rdy/data got %b/%h exp %b/%h", $time, bus.rdy, bus.data, m_rdy, m_data);
      end
`ifdef RX_FRAMING_CHECK_EN
      checks++;
      if (bus.ferr !== m_ferr) begin
        errors++;
        $display("FAIL cycle_ferr t=%0t got %b exp %b", $time, bus.ferr, m_ferr);
      end
      if (bus.ferr === 1'b1) dut_ferr_cycles++;
`endif
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk_50m);
  endtask

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", name, got, exp);
    end
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop, input int stop_cyc);
    bus.rx = 1'b0;
    cyc(BitCyc);
    for (int i = 0; i < 8; i++) begin
      bus.rx = b[i];
      cyc(BitCyc);
    end
    bus.rx = stop;
    cyc(stop_cyc);
    bus.rx = 1'b1;
  endtask

  task automatic wait_rdy(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (bus.rdy === 1'b1) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk_50m);
    end
  endtask

  initial begin
    #(20 * 90000);
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    bit ok;
    int ferr_base;
    rst    = 1'b1;
    bus.rx = 1'b1;
    cyc(3);
    rst    = 1'b0;
    cmp_en = 1'b1;
    check("reset_rdy", 32'(bus.rdy), 0);
    check("reset_data", 32'(bus.data), 32'h00);
`ifdef RX_FRAMING_CHECK_EN
    check("reset_ferr", 32'(bus.ferr), 0);
`endif

    cyc(2000);
    check("idle_rdy", 32'(bus.rdy), 0);
    check("idle_data", 32'(bus.data), 32'h00);

    // A5, cleared 10 cycles after rdy rises
    fork
      send_frame(8'hA5, 1'b1, BitCyc);
      begin
        wait_rdy(6000, ok);
        check("a5_rdy_rise", 32'(ok), 1);
        check("a5_data", 32'(bus.data), 32'hA5);
        cyc(10);
        clr_reqs++;
        cyc(3);
        check("a5_rdy_cleared", 32'(bus.rdy), 0);
      end
    join

    // Back-to-back frames overwrite without clear
    send_frame(8'h3C, 1'b1, BitCyc);
    check("3c_data", 32'(bus.data), 32'h3C);
    send_frame(8'h81, 1'b1, BitCyc);
    check("81_data", 32'(bus.data), 32'h81);
    check("81_rdy", 32'(bus.rdy), 1);

    // 55 with rdy_clr landing on its set edge
    arm_id++;
    send_frame(8'h55, 1'b1, BitCyc);
    check("55_coinc_clr_issued", 32'(coinc_id), 32'(arm_id));
    check("55_rdy", 32'(bus.rdy), 1);
    check("55_data", 32'(bus.data), 32'h55);
    clr_reqs++;
    cyc(3);
    check("55_rdy_cleared", 32'(bus.rdy), 0);

    // Short low glitch of 4 ticks
    ferr_base = dut_ferr_cycles;
    bus.rx = 1'b0;
    cyc(4 * ClkenDiv);
    bus.rx = 1'b1;
    cyc(600);
    check("glitch_rdy", 32'(bus.rdy), 0);
    check("glitch_data", 32'(bus.data), 32'h55);
    check("glitch_ferr", 32'(dut_ferr_cycles - ferr_base), 0);

    // F0 with a low stop bit
    ferr_base = dut_ferr_cycles;
    send_frame(8'hF0, 1'b0, 9 * ClkenDiv);
    cyc(800);
`ifdef RX_FRAMING_CHECK_EN
    check("f0_ferr_pulses", 32'(dut_ferr_cycles - ferr_base), 1);
    check("f0_rdy", 32'(bus.rdy), 0);
    check("f0_data_kept", 32'(bus.data), 32'h55);
`else
    check("f0_rdy", 32'(bus.rdy), 1);
    check("f0_data", 32'(bus.data), 32'hF0);
`endif

    // Reset in the middle of bit 4 of FF, then 12
    fork
      send_frame(8'hFF, 1'b1, BitCyc);
      begin
        cyc(BitCyc * 5 + BitCyc / 2);
        rst = 1'b1;
        cyc(1);
        rst = 1'b0;
      end
    join
    cyc(200);
    check("ff_aborted_rdy", 32'(bus.rdy), 0);
    check("ff_aborted_data", 32'(bus.data), 32'h00);
    send_frame(8'h12, 1'b1, BitCyc);
    check("12_rdy", 32'(bus.rdy), 1);
    check("12_data", 32'(bus.data), 32'h12);

    cyc(10);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
